wb_column_config_loader: RTL
============================

// Module: wb_column_config_loader
// PURPOSE
//   Wishbone slave that accepts the fabric bitstream as byte-wide bus writes and shifts
//   it serially, LSB first, into one configuration chain per fabric column.
//   Sits between the Caravel Wishbone bus and the per-column CLB config shift chains.
//   Byte lane c of a data write feeds column c; all columns shift in parallel.
//   A data write stalls (ack withheld) until its bits are fully shifted.
// PARAMETERS
//   NUM_COLS   3             fabric columns, 1..4 (one Wishbone byte lane each)
//   BASE_ADDR  32'h3000_0000 block base; addr[31:8] must match BASE_ADDR[31:8]
// PORTS
//   wb_clk_i    in   1          single clock
//   wb_rst_i    in   1          reset, synchronous, active-low
//   wbs_stb_i   in   1          strobe
//   wbs_cyc_i   in   1          cycle valid
//   wbs_we_i    in   1          1 = write
//   wbs_sel_i   in   4          byte-lane write mask
//   wbs_addr_i  in   32         byte address
//   wbs_data_i  in   32         write data
//   wbs_ack_o   out  1          one-cycle acknowledge
//   wbs_data_o  out  32         read data, valid while ack high
//   cfg_en_o    out  NUM_COLS   per-column shift enable
//   cfg_bit_o   out  NUM_COLS   per-column serial config bit
//   busy_o      out  1          high while in SHIFT
// BEHAVIOUR
//   - Request = stb & cyc & addr[31:8]==BASE_ADDR[31:8]; sampled only in IDLE with ack low.
//     Non-matching address: ignored, never acked.
//   - Offsets (addr[7:0]): 0x00 status (read), 0x01 count (write), 0x02 data (write);
//     any other offset, or a read of 0x01/0x02: ack next cycle, no effect, data_o=0.
//   - Count reg: byte c -> cnt[c], 4 bits, reset 8; written value >8 clamps to 8
//     (0xFF -> 8). Only lanes with sel[c]=1 and c<NUM_COLS update. Ack next cycle.
//   - Data write: lanes with sel[c]=1 load shreg[c]=data byte c, rem[c]=cnt[c];
//     lanes with sel[c]=0 get rem[c]=0. M = max rem[c].
//   - FSM IDLE -> SHIFT (M>0) or ACK (M=0); SHIFT -> ACK when all rem==0; ACK -> IDLE.
//   - SHIFT, per column per cycle: if rem[c]>0 then cfg_en_o[c]=1, cfg_bit_o[c]=shreg[c][0],
//     shreg>>=1, rem--; else cfg_en_o[c]=0, cfg_bit_o[c]=0. Columns with shorter
//     counts go idle early while others finish.
//   - Timing: request sampled at edge T; cfg_en high cycles T+1..T+M; ack high in cycle
//     T+M+1 only. Control/count accesses: ack in cycle T+1.
//   - ack is a single-cycle pulse; a request still held during ack is not re-sampled;
//     next request accepted the cycle after ack falls.
//   - Outputs outside SHIFT: cfg_en_o=0, cfg_bit_o=0, busy_o=0.
//   - Reset (any state, incl. mid-SHIFT): IDLE, ack=0, data_o=0, cfg_en/bit=0, busy=0,
//     cnt[*]=8, shreg/rem=0; partially shifted bits are not replayed.
//   - Status read (0x00): data_o = {busy(=0 in IDLE), 31'b0} unless CFG_READBACK_EN.
// CONFIGURATION
//   CFG_READBACK_EN defined: 24-bit bit counter total_bits increments by popcount(cfg_en_o)
//     each SHIFT cycle, saturates at 2^24-1, reset 0; status read returns
//     {busy, 3'b0, cnt[1], cnt[0] packed in [27:24]... no: [27:24]=cnt[0], [23:0]=total_bits}.
//   CFG_READBACK_EN undefined: no counter; status read returns 32'h0.
// TESTING
//   1 Reset low 10 cycles mid-SHIFT -> ack/cfg_en/busy 0 next edge; status read = 0.
//   2 Write 0x3000_0001 data 0xFFFF_FFFF sel 4'hF -> ack at T+1; cnt[0..2]=8.
//   3 Write 0x3000_0002 data 0x00C3_5AA5 -> cfg_en=3'b111 for 8 cycles; col0 bits
//     1,0,1,0,0,1,0,1; col1 0,1,0,1,1,0,1,0; col2 1,1,0,0,0,0,1,1; ack at T+9.
//   4 Count 0x0000_0503 (col0=3,col1=5,col2=0) then data 0x0000_FF07 -> col0 en 3 cycles,
//     col1 en 5 cycles, col2 never; ack at T+6; count 0 everywhere -> ack at T+1.
//   5 Wrong address 0x3100_0002 -> no ack, no cfg_en; sel=4'b0010 data write -> only col1 shifts.
//   6 CFG_READBACK_EN: after test 3 status read [23:0]=24 (3x8); without macro reads 0.

Source files
------------

// File: rtl/wb_column_config_loader.sv
// Wishbone slave that shifts byte-lane write data LSB-first into one config chain per fabric column.
// Build macro CFG_READBACK_EN adds a saturating shifted-bit counter and count readback to the status word.
module wb_column_config_loader #(
   parameter int          NUM_COLS  = 3,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_addr_i,
   input  logic [31:0]         wbs_data_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_data_o,
   output logic [NUM_COLS-1:0] cfg_en_o,
   output logic [NUM_COLS-1:0] cfg_bit_o,
   output logic                busy_o
);

   localparam logic [7:0] OFF_STATUS = 8'h00;
   localparam logic [7:0] OFF_COUNT  = 8'h01;
   localparam logic [7:0] OFF_DATA   = 8'h02;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_ACK
   } state_t;

   state_t                state_reg;
   state_t                state_next;
   logic                  req;
   logic                  accept;
   logic                  cnt_wr;
   logic                  data_wr;
   logic                  status_rd;
   logic [NUM_COLS-1:0]   load_nz;
   logic [NUM_COLS-1:0]   rem_last;
   logic [4*NUM_COLS-1:0] cnt_flat;
   logic [31:0]           rdata_reg;
   logic [31:0]           status_word;
   logic                  unused_bus;

   // Requests are only looked at in IDLE, so a request held through ACK is not taken twice.
   assign req       = wbs_stb_i & wbs_cyc_i & (wbs_addr_i[31:8] == BASE_ADDR[31:8]);
   assign accept    = req & (state_reg == ST_IDLE);
   assign cnt_wr    = accept &  wbs_we_i & (wbs_addr_i[7:0] == OFF_COUNT);
   assign data_wr   = accept &  wbs_we_i & (wbs_addr_i[7:0] == OFF_DATA);
   assign status_rd = accept & ~wbs_we_i & (wbs_addr_i[7:0] == OFF_STATUS);

   // Lanes beyond NUM_COLS are intentionally dropped.
   assign unused_bus = ^{wbs_sel_i, wbs_data_i, cnt_flat};

   generate
      for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
         logic [7:0] lane;
         logic [3:0] cnt_reg;
         logic [3:0] rem_reg;
         logic [7:0] shreg_reg;

         assign lane = wbs_data_i[8*gi +: 8];

         always_ff @(posedge wb_clk_i) begin
            if (!wb_rst_i) begin
               cnt_reg   <= 4'd8;
               rem_reg   <= 4'd0;
               shreg_reg <= 8'd0;
            end else begin
               if (cnt_wr && wbs_sel_i[gi]) begin
                  cnt_reg <= (lane > 8'd8) ? 4'd8 : lane[3:0];
               end
               if (data_wr) begin
                  if (wbs_sel_i[gi]) begin
                     shreg_reg <= lane;
                  end
                  rem_reg <= wbs_sel_i[gi] ? cnt_reg : 4'd0;
               end else if ((state_reg == ST_SHIFT) && (rem_reg != 4'd0)) begin
                  shreg_reg <= {1'b0, shreg_reg[7:1]};
                  rem_reg   <= rem_reg - 4'd1;
               end
            end
         end

         assign load_nz[gi]           = wbs_sel_i[gi] & (cnt_reg != 4'd0);
         assign rem_last[gi]          = (rem_reg <= 4'd1);
         assign cfg_en_o[gi]          = (state_reg == ST_SHIFT) & (rem_reg != 4'd0);
         assign cfg_bit_o[gi]         = cfg_en_o[gi] & shreg_reg[0];
         assign cnt_flat[4*gi +: 4]   = cnt_reg;
      end
   endgenerate

`ifdef CFG_READBACK_EN
   logic [23:0] total_bits_reg;
   logic [2:0]  en_pop;
   logic [24:0] total_sum;

   always_comb begin
      en_pop = 3'd0;
      for (int c = 0; c < NUM_COLS; c++) begin
         en_pop = en_pop + {2'b00, cfg_en_o[c]};
      end
      total_sum = {1'b0, total_bits_reg} + {22'd0, en_pop};
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         total_bits_reg <= 24'd0;
      end else if (state_reg == ST_SHIFT) begin
         total_bits_reg <= total_sum[24] ? 24'hFF_FFFF : total_sum[23:0];
      end
   end

   assign status_word = {busy_o, 3'b000, cnt_flat[3:0], total_bits_reg};
`else
   assign status_word = 32'h0000_0000;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_reg <= ST_IDLE;
         rdata_reg <= 32'd0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            rdata_reg <= status_rd ? status_word : 32'd0;
         end else if (state_reg == ST_ACK) begin
            rdata_reg <= 32'd0;
         end
      end
   end

   // SHIFT ends on the edge that retires the last bit so ack lands exactly M+1 cycles after the request.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next = (data_wr && (|load_nz)) ? ST_SHIFT : ST_ACK;
            end
         end
         ST_SHIFT: begin
            if (&rem_last) begin
               state_next = ST_ACK;
            end
         end
         ST_ACK: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign wbs_ack_o  = (state_reg == ST_ACK);
   assign wbs_data_o = rdata_reg;
   assign busy_o     = (state_reg == ST_SHIFT);

endmodule
